serial_subtractor_ctrl: RTL

Bit-serial N-bit subtractor built around a single full-subtractor cell. A controller FSM sequences the cell LSB-first over WIDTH cycles and registers the borrow between bit-steps. It presents a start/busy/done handshake to the requester and holds the registered result, final borrow and signed-overflow flag until the next completion. It is the area-minimal alternative to a ripple array of full-subtractor cells.

---
 rtl/serial_subtractor_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell is stepped
// LSB-first over WIDTH clock edges by a small IDLE/RUN controller.
// Result, final borrow and signed-overflow flag are registered and held
// until the next completion; done pulses for one cycle at completion.
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  // Counter must be at least one bit wide even when WIDTH is 1.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Full-subtractor cell: returns {borrow_out, difference_bit}.
  function automatic logic [1:0] fs_cell(input logic x, input logic y, input logic r);
    logic d_bit;
    logic b_bit;
    d_bit = x ^ y ^ r;
    b_bit = (~x & y) | (~(x ^ y) & r);
    return {b_bit, d_bit};
  endfunction

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             brw_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             ovf_q;

  logic             d_s;
  logic             brw_d;
  logic [WIDTH:0]   res_cat_s;
  logic [WIDTH-1:0] res_d;
  logic             ovf_d;
  logic             last_s;

  // Cell evaluation on the current LSBs plus next result/overflow values.
  // On the final step the operand LSBs are the captured sign bits, so the
  // overflow flag can be formed directly from the cell inputs and output.
  always_comb begin
    {brw_d, d_s} = fs_cell(a_q[0], b_q[0], brw_q);
    res_cat_s    = {d_s, res_q};
    res_d        = res_cat_s[WIDTH:1];
    ovf_d        = (a_q[0] != b_q[0]) && (d_s != a_q[0]);
    last_s       = (cnt_q == LAST_BIT);
  end

  // Controller FSM with datapath registers and registered handshake/result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            brw_q   <= bin;
            res_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          res_q <= res_d;
          brw_q <= brw_d;
          if (last_s) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            diff_q  <= res_d;
            bout_q  <= brw_d;
            ovf_q   <= ovf_d;
          end else begin
            cnt_q   <= cnt_q + CW'(1);
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

endmodule
